// File: rtl/adder_tree_frame_packer.sv
// Purpose : packs a LANES-wide valid/ready sample stream into one NUM_INPUTS-wide frame for the adder tree.
// Latency : 1 cycle from the completing beat (full frame or s_last) to the o_valid pulse.
// Backpressure: none from downstream; s_ready is low only in reset and the one IDLE cycle after it.
//
// Ports:
//   clk, rst          rising-edge clock; synchronous active-low reset
//   s_valid/s_ready   beat handshake; s_data lane k at [k*DATAWIDTH +: DATAWIDTH]
//   s_last            final beat of a (possibly short) frame; only sampled on accepted beats
//   o_valid           one-cycle pulse; o_data/o_count hold until the next frame completes
//   o_data            packed frame, slot 0 = first sample received, unwritten slots = 0
//   o_count           number of real samples in o_data
//   o_frame_cnt       (ADDER_TREE_FRAME_PACKER_STATS_EN only) frames emitted, wraps
//   o_short_cnt       (ADDER_TREE_FRAME_PACKER_STATS_EN only) short frames emitted, wraps
//
// Optional feature macro: ADDER_TREE_FRAME_PACKER_STATS_EN

module adder_tree_frame_packer #(
    parameter int DATAWIDTH  = 4,
    parameter int NUM_INPUTS = 16,
    parameter int LANES      = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [LANES*DATAWIDTH-1:0]             s_data,
    input  logic                                   s_last,
    output logic                                   o_valid,
    output logic [NUM_INPUTS-1:0][DATAWIDTH-1:0]   o_data,
    output logic [$clog2(NUM_INPUTS+1)-1:0]        o_count
`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
    ,
    output logic [15:0]                            o_frame_cnt,
    output logic [15:0]                            o_short_cnt
`endif
);

    localparam int CW = $clog2(NUM_INPUTS + 1);

    // A frame must be an integer number of beats, otherwise the slot
    // pointer would step past the end of the buffer.
    if ((NUM_INPUTS % LANES) != 0) begin : g_bad_lanes
        $error("adder_tree_frame_packer: LANES must divide NUM_INPUTS");
    end

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                                state;
    logic [CW-1:0]                         ptr;
    logic [CW-1:0]                         ptr_nxt;
    logic [NUM_INPUTS-1:0][DATAWIDTH-1:0]  fill_buf;
    logic [NUM_INPUTS-1:0][DATAWIDTH-1:0]  buf_nxt;
    logic                                  accept;
    logic                                  frame_done;

    assign accept     = s_valid & s_ready;
    assign ptr_nxt    = ptr + CW'(LANES);
    assign frame_done = accept & ((ptr_nxt == CW'(NUM_INPUTS)) | s_last);

    // ptr is always a multiple of LANES, so slot s belongs to the current
    // beat exactly when ptr equals the base slot of s's beat; its lane
    // within the beat is s % LANES. Constant slot indices keep this free
    // of variable-width array indexing.
    always_comb begin
        buf_nxt = fill_buf;
        for (int s = 0; s < NUM_INPUTS; s++) begin
            if (ptr == CW'(s - (s % LANES))) begin
                buf_nxt[s] = s_data[(s % LANES)*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            s_ready     <= 1'b0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_count     <= '0;
            fill_buf    <= '0;
            ptr         <= '0;
`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
            o_frame_cnt <= '0;
            o_short_cnt <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    state   <= FILL;
                    s_ready <= 1'b1;
                end
                FILL: begin
                    s_ready <= 1'b1;
                    if (frame_done) begin
                        // Emit the buffer including this beat's lanes and
                        // restart at slot 0 so the next beat needs no bubble.
                        o_data   <= buf_nxt;
                        o_count  <= ptr_nxt;
                        o_valid  <= 1'b1;
                        fill_buf <= '0;
                        ptr      <= '0;
`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                        if (ptr_nxt < CW'(NUM_INPUTS)) begin
                            o_short_cnt <= o_short_cnt + 16'd1;
                        end
`endif
                    end else if (accept) begin
                        fill_buf <= buf_nxt;
                        ptr      <= ptr_nxt;
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_frame_packer.sv
// Purpose : directed self-checking bench for adder_tree_frame_packer (LANES=1, 4 and 16 instances).
// Latency : expects o_valid one cycle after the completing beat.
// Backpressure: stimulus assumes s_ready high in FILL; s_ready itself is checked around reset.

module tb_adder_tree_frame_packer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // LANES=1 instance
    logic              s1_valid = 1'b0;
    logic              s1_ready;
    logic [3:0]        s1_data  = '0;
    logic              s1_last  = 1'b0;
    logic              o1_valid;
    logic [15:0][3:0]  o1_data;
    logic [4:0]        o1_count;
`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
    logic [15:0]       o1_frame_cnt;
    logic [15:0]       o1_short_cnt;
`endif

    // LANES=4 instance
    logic              s4_valid = 1'b0;
    logic              s4_ready;
    logic [15:0]       s4_data  = '0;
    logic              s4_last  = 1'b0;
    logic              o4_valid;
    logic [15:0][3:0]  o4_data;
    logic [4:0]        o4_count;
`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
    logic [15:0]       o4_frame_cnt;
    logic [15:0]       o4_short_cnt;
`endif

    // LANES=16 instance
    logic              s16_valid = 1'b0;
    logic              s16_ready;
    logic [63:0]       s16_data  = '0;
    logic              s16_last  = 1'b0;
    logic              o16_valid;
    logic [15:0][3:0]  o16_data;
    logic [4:0]        o16_count;
`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
    logic [15:0]       o16_frame_cnt;
    logic [15:0]       o16_short_cnt;
`endif

    adder_tree_frame_packer #(.DATAWIDTH(4), .NUM_INPUTS(16), .LANES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data), .s_last(s1_last),
        .o_valid(o1_valid), .o_data(o1_data), .o_count(o1_count)
`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
        , .o_frame_cnt(o1_frame_cnt), .o_short_cnt(o1_short_cnt)
`endif
    );

    adder_tree_frame_packer #(.DATAWIDTH(4), .NUM_INPUTS(16), .LANES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .s_valid(s4_valid), .s_ready(s4_ready), .s_data(s4_data), .s_last(s4_last),
        .o_valid(o4_valid), .o_data(o4_data), .o_count(o4_count)
`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
        , .o_frame_cnt(o4_frame_cnt), .o_short_cnt(o4_short_cnt)
`endif
    );

    adder_tree_frame_packer #(.DATAWIDTH(4), .NUM_INPUTS(16), .LANES(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .s_valid(s16_valid), .s_ready(s16_ready), .s_data(s16_data), .s_last(s16_last),
        .o_valid(o16_valid), .o_data(o16_data), .o_count(o16_count)
`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
        , .o_frame_cnt(o16_frame_cnt), .o_short_cnt(o16_short_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // o_valid pulse counters, sampled just after each rising edge
    int p1  = 0;
    int p4  = 0;
    int p16 = 0;

    always @(posedge clk) begin
        #1;
        if (o1_valid)  p1++;
        if (o4_valid)  p4++;
        if (o16_valid) p16++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of the LANES=1 stream at the falling edge.
    task automatic drive1(input logic v, input logic [3:0] d, input logic l);
        @(negedge clk);
        s1_valid = v;
        s1_data  = d;
        s1_last  = l;
    endtask

    task automatic drive4(input logic v, input logic [15:0] d, input logic l);
        @(negedge clk);
        s4_valid = v;
        s4_data  = d;
        s4_last  = l;
    endtask

    // Watchdog: the run is a few hundred cycles; anything far beyond is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        // ---------------- reset state and s_ready rise ----------------
        repeat (3) @(negedge clk);
        check("rst_ready",   64'(s1_ready), 64'd0);
        check("rst_valid",   64'(o1_valid), 64'd0);
        check("rst_data",    64'(o1_data),  64'd0);
        check("rst_count",   64'(o1_count), 64'd0);
`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
        check("rst_frame_cnt", 64'(o1_frame_cnt), 64'd0);
        check("rst_short_cnt", 64'(o1_short_cnt), 64'd0);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("ready_rise", 64'(s1_ready), 64'd1);

        // ---------------- full frame 0..15 ----------------
        base = p1;
        for (int i = 0; i < 16; i++) drive1(1'b1, 4'(i), 1'b0);
        check("t1_no_early", 64'(o1_valid), 64'd0);
        drive1(1'b0, 4'd0, 1'b0);
        check("t1_valid",  64'(o1_valid), 64'd1);
        check("t1_data",   64'(o1_data),  64'hFEDC_BA98_7654_3210);
        check("t1_count",  64'(o1_count), 64'd16);
        check("t1_pulses", 64'(p1 - base), 64'd1);
        @(negedge clk);
        check("t1_pulse_end", 64'(o1_valid), 64'd0);
        check("t1_hold_data", 64'(o1_data),  64'hFEDC_BA98_7654_3210);

        // ---------------- short frame then full frame of 1s ----------------
        base = p1;
        for (int i = 0; i < 5; i++) drive1(1'b1, 4'd3, (i == 4));
        drive1(1'b0, 4'd0, 1'b0);
        check("t2_valid", 64'(o1_valid), 64'd1);
        check("t2_data",  64'(o1_data),  64'h0000_0000_0003_3333);
        check("t2_count", 64'(o1_count), 64'd5);
        for (int i = 0; i < 16; i++) drive1(1'b1, 4'd1, 1'b0);
        drive1(1'b0, 4'd0, 1'b0);
        check("t2_full_data",  64'(o1_data),  64'h1111_1111_1111_1111);
        check("t2_full_count", 64'(o1_count), 64'd16);
        check("t2_pulses",     64'(p1 - base), 64'd2);

        // ---------------- gaps (with s_last on idle cycles) ----------------
        base = p1;
        for (int i = 0; i < 16; i++) begin
            drive1(1'b1, 4'hF, 1'b0);
            if (i == 1 || i == 6 || i == 10) begin
                drive1(1'b0, 4'h0, 1'b1);
                drive1(1'b0, 4'h0, 1'b1);
            end
        end
        check("t3_gap_no_pulse", 64'(p1 - base), 64'd0);
        drive1(1'b0, 4'd0, 1'b0);
        check("t3_valid",  64'(o1_valid), 64'd1);
        check("t3_data",   64'(o1_data),  64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_count",  64'(o1_count), 64'd16);
        check("t3_pulses", 64'(p1 - base), 64'd1);

        // ---------------- reset mid-frame ----------------
        base = p1;
        for (int i = 0; i < 9; i++) drive1(1'b1, 4'd5, 1'b0);
        @(negedge clk);
        s1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t4_ready_idle", 64'(s1_ready), 64'd0);
        check("t4_rst_data",   64'(o1_data),  64'd0);
        check("t4_rst_count",  64'(o1_count), 64'd0);
        @(negedge clk);
        check("t4_ready_back", 64'(s1_ready), 64'd1);
        check("t4_no_partial", 64'(p1 - base), 64'd0);
        // s_last together with the frame-filling beat: exactly one frame
        for (int i = 0; i < 16; i++) drive1(1'b1, 4'd1, (i == 15));
        drive1(1'b0, 4'd0, 1'b0);
        check("t4_valid", 64'(o1_valid), 64'd1);
        check("t4_data",  64'(o1_data),  64'h1111_1111_1111_1111);
        check("t4_count", 64'(o1_count), 64'd16);
        @(negedge clk);
        check("t4_no_extra", 64'(o1_valid), 64'd0);
        check("t4_pulses",   64'(p1 - base), 64'd1);

        // ---------------- LANES=4 ----------------
        check("t5_ready4", 64'(s4_ready), 64'd1);
        base = p4;
        drive4(1'b1, 16'h3210, 1'b0);
        drive4(1'b1, 16'h7654, 1'b0);
        drive4(1'b1, 16'hBA98, 1'b0);
        drive4(1'b1, 16'hFEDC, 1'b0);
        check("t5_no_early4", 64'(o4_valid), 64'd0);
        drive4(1'b0, 16'h0, 1'b0);
        check("t5_valid4",  64'(o4_valid), 64'd1);
        check("t5_data4",   64'(o4_data),  64'hFEDC_BA98_7654_3210);
        check("t5_count4",  64'(o4_count), 64'd16);
        check("t5_pulses4", 64'(p4 - base), 64'd1);

        // ---------------- LANES=16 back-to-back ----------------
        check("t6_ready16", 64'(s16_ready), 64'd1);
        base = p16;
        @(negedge clk);
        s16_valid = 1'b1;
        s16_data  = 64'hFEDC_BA98_7654_3210;
        @(negedge clk);
        s16_data  = 64'h0123_4567_89AB_CDEF;
        check("t6_valid_a", 64'(o16_valid), 64'd1);
        check("t6_data_a",  64'(o16_data),  64'hFEDC_BA98_7654_3210);
        @(negedge clk);
        s16_valid = 1'b0;
        check("t6_valid_b", 64'(o16_valid), 64'd1);
        check("t6_data_b",  64'(o16_data),  64'h0123_4567_89AB_CDEF);
        check("t6_count_b", 64'(o16_count), 64'd16);
        @(negedge clk);
        check("t6_end",     64'(o16_valid), 64'd0);
        check("t6_pulses",  64'(p16 - base), 64'd2);

`ifdef ADDER_TREE_FRAME_PACKER_STATS_EN
        // ---------------- statistics counters ----------------
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("st_rst_frame", 64'(o1_frame_cnt), 64'd0);
        check("st_rst_short", 64'(o1_short_cnt), 64'd0);
        @(negedge clk);
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 16; i++) drive1(1'b1, 4'd2, 1'b0);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 3; i++) drive1(1'b1, 4'd4, (i == 2));
        drive1(1'b0, 4'd0, 1'b0);
        check("st_valid",     64'(o1_valid),     64'd1);
        check("st_frame_cnt", 64'(o1_frame_cnt), 64'd5);
        check("st_short_cnt", 64'(o1_short_cnt), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
